// File: rtl/laser_host.sv
// Host-side loader, streamer and independent rescorer for the two-circle laser coverage core.
// Optional WAIT watchdog enabled by defining LASER_HOST_TIMEOUT_EN.
module laser_host #(
  parameter int NUM_IMG = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            LD_EN,
  input  logic [$clog2(NUM_IMG*40)-1:0]   LD_ADDR,
  input  logic [7:0]                      LD_DATA,
  input  logic                            START,
  output logic                            LRST,
  output logic [3:0]                      X,
  output logic [3:0]                      Y,
  input  logic                            DONE,
  input  logic [3:0]                      C1X,
  input  logic [3:0]                      C1Y,
  input  logic [3:0]                      C2X,
  input  logic [3:0]                      C2Y,
  output logic                            BUSY,
  output logic                            RES_VALID,
  output logic [3:0]                      RES_IMG,
  output logic [3:0]                      RES_C1X,
  output logic [3:0]                      RES_C1Y,
  output logic [3:0]                      RES_C2X,
  output logic [3:0]                      RES_C2Y,
  output logic [5:0]                      RES_SCORE,
  output logic                            RUN_DONE,
  output logic                            ERR
);

  localparam int DEPTH = NUM_IMG * 40;
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_IMG = 4'(NUM_IMG - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [5:0]    ptr;
  logic [3:0]    img;
  logic          last_img;
  logic [AW-1:0] stream_addr;
  logic [7:0]    stream_pt;
  logic          done_take;
  logic          timeout_hit;

  logic          sc_active;
  logic          sc_last_run;
  logic [5:0]    sc_cnt;
  logic [3:0]    sc_img;
  logic [AW-1:0] score_addr;
  logic [7:0]    score_pt;
  logic          cov_p1;
  logic          vld_p1;
  logic          last_p1;
  logic [5:0]    acc;
  logic          sc_fin;

  function automatic logic [AW-1:0] pt_addr(input logic [3:0] im, input logic [5:0] n);
    return AW'(im) * AW'(40) + AW'(n);
  endfunction

  // Differences are taken in 5-bit signed so that 0 vs 15 is 15 apart, not 1.
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic signed [9:0] dxw;
    logic signed [9:0] dyw;
    dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxw = dx;
    dyw = dy;
    return 9'(dxw * dxw + dyw * dyw);
  endfunction

  function automatic logic covered(input logic [8:0] d1, input logic [8:0] d2);
    return (d1 <= 9'd16) || (d2 <= 9'd16);
  endfunction

  // Point memory keeps its contents across runs and resets.
  always_ff @(posedge CLK) begin
    if (LD_EN && !BUSY && (int'(LD_ADDR) < DEPTH)) mem[LD_ADDR] <= LD_DATA;
  end

  assign last_img = (img == LAST_IMG);

  always_comb begin
    stream_addr = '0;
    if (state == STREAM) begin
      if (ptr < 6'd40) stream_addr = pt_addr(img, ptr);
      else if (!last_img) stream_addr = pt_addr(img + 4'd1, 6'd0);
    end
  end

  assign stream_pt = mem[stream_addr];
  assign done_take = (state == WAIT) && DONE;

`ifdef LASER_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  assign timeout_hit = (state == WAIT) && !DONE && (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      LRST    <= 1'b1;
      X       <= '0;
      Y       <= '0;
      ptr     <= '0;
      img     <= '0;
      BUSY    <= 1'b0;
      RES_IMG <= '0;
      RES_C1X <= '0;
      RES_C1Y <= '0;
      RES_C2X <= '0;
      RES_C2Y <= '0;
`ifdef LASER_HOST_TIMEOUT_EN
      wait_cnt <= '0;
      ERR      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START && !BUSY) begin
            LRST   <= 1'b0;
            {X, Y} <= stream_pt;
            ptr    <= 6'd1;
            img    <= '0;
            BUSY   <= 1'b1;
            state  <= STREAM;
`ifdef LASER_HOST_TIMEOUT_EN
            ERR    <= 1'b0;
`endif
          end else if (sc_fin) begin
            BUSY <= 1'b0;
          end
        end
        STREAM: begin
          if (ptr < 6'd40) begin
            {X, Y} <= stream_pt;
            ptr    <= ptr + 6'd1;
          end else begin
            // Pre-present the next image's first point while the core computes.
            {X, Y} <= last_img ? 8'h00 : stream_pt;
            state  <= WAIT;
`ifdef LASER_HOST_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (DONE) begin
            RES_C1X <= C1X;
            RES_C1Y <= C1Y;
            RES_C2X <= C2X;
            RES_C2Y <= C2Y;
            RES_IMG <= img;
            if (!last_img) begin
              img   <= img + 4'd1;
              ptr   <= 6'd1;
              state <= STREAM;
            end else begin
              LRST  <= 1'b1;
              state <= IDLE;
            end
          end
`ifdef LASER_HOST_TIMEOUT_EN
          else if (timeout_hit) begin
            ERR    <= 1'b1;
            LRST   <= 1'b1;
            BUSY   <= 1'b0;
            {X, Y} <= 8'h00;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign score_addr = pt_addr(sc_img, sc_cnt);
  assign score_pt   = mem[score_addr];
  assign sc_fin     = vld_p1 && last_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_active   <= 1'b0;
      sc_last_run <= 1'b0;
      sc_cnt      <= '0;
      sc_img      <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      RES_VALID   <= 1'b0;
      RES_SCORE   <= '0;
      RUN_DONE    <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      RUN_DONE  <= 1'b0;
      if (timeout_hit) begin
        sc_active <= 1'b0;
        vld_p1    <= 1'b0;
        last_p1   <= 1'b0;
      end else begin
        // Stage p0 -> p1: one point read and classified per cycle.
        vld_p1  <= sc_active;
        last_p1 <= sc_active && (sc_cnt == 6'd39);
        if (done_take) begin
          sc_active   <= 1'b1;
          sc_cnt      <= '0;
          sc_img      <= img;
          sc_last_run <= last_img;
        end else if (sc_active) begin
          sc_cnt <= sc_cnt + 6'd1;
          if (sc_cnt == 6'd39) sc_active <= 1'b0;
        end
        // Stage p1 -> result: final accumulate and publish.
        if (sc_fin) begin
          RES_VALID <= 1'b1;
          RUN_DONE  <= sc_last_run;
          RES_SCORE <= acc + {5'd0, cov_p1};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    cov_p1 <= covered(dist_sq(score_pt[7:4], score_pt[3:0], RES_C1X, RES_C1Y),
                      dist_sq(score_pt[7:4], score_pt[3:0], RES_C2X, RES_C2Y));
    if (done_take) acc <= '0;
    else if (vld_p1) acc <= acc + {5'd0, cov_p1};
  end

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host with two images; watchdog steps apply when LASER_HOST_TIMEOUT_EN is defined.
module tb_laser_host;

  localparam int NI = 2;
  localparam int AW = $clog2(NI * 40);

  logic          CLK = 1'b0;
  logic          RST;
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [7:0]    LD_DATA;
  logic          START;
  logic          LRST;
  logic [3:0]    X, Y;
  logic          DONE;
  logic [3:0]    C1X, C1Y, C2X, C2Y;
  logic          BUSY, RES_VALID, RUN_DONE, ERR;
  logic [3:0]    RES_IMG, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0]    RES_SCORE;

  int checks = 0;
  int failures = 0;

  laser_host #(.NUM_IMG(NI), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .START(START), .LRST(LRST), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .BUSY(BUSY),
    .RES_VALID(RES_VALID), .RES_IMG(RES_IMG), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y),
    .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y), .RES_SCORE(RES_SCORE),
    .RUN_DONE(RUN_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    LD_EN = 1'b1;
    LD_ADDR = AW'(a);
    LD_DATA = d;
    tick();
    LD_EN = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic give_done(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    DONE = 1'b1;
    C1X = a; C1Y = b; C2X = c; C2Y = d;
    tick();
    DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
  endtask

  task automatic wait_result(input string tag, input int bound, input int exp);
    int lat = 0;
    while (RES_VALID !== 1'b1 && lat < bound) begin
      tick();
      lat++;
    end
    check(tag, lat, exp);
  endtask

  initial begin
    int bad;
    RST = 1'b1; LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0; START = 1'b0; DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) tick();
    check("rst_lrst", LRST, 1);
    check("rst_busy", BUSY, 0);
    check("rst_xy", {X, Y}, 0);
    check("rst_valid", RES_VALID, 0);
    check("rst_score", RES_SCORE, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 40; i++) load(i, 8'h55);
    for (int i = 0; i < 40; i++) load(40 + i, (i % 2 == 1) ? 8'hEE : 8'h11);

    // Run 1: uniform image then alternating (1,1)/(14,14) image.
    pulse_start();
    check("start_lrst", LRST, 0);
    check("start_busy", BUSY, 1);
    check("start_p0", {X, Y}, 8'h55);
    bad = 0;
    for (int k = 1; k < 40; k++) begin
      tick();
      if ({X, Y} !== 8'h55) bad++;
    end
    check("stream_img0", bad, 0);
    tick();
    check("wait_next_p0", {X, Y}, 8'h11);
    repeat (3) tick();
    check("wait_hold_p0", {X, Y}, 8'h11);
    give_done(5, 5, 5, 5);
    check("cap_c1x", RES_C1X, 5);
    check("cap_img0", RES_IMG, 0);
    check("after_done_p0", {X, Y}, 8'h11);
    tick();
    check("second_after_p1", {X, Y}, 8'hEE);
    wait_result("lat_img0", 60, 40);
    check("score_img0", RES_SCORE, 40);
    check("res_img0", RES_IMG, 0);
    check("rundone_img0", RUN_DONE, 0);
    check("busy_mid", BUSY, 1);
    check("last_wait_xy", {X, Y}, 0);
    give_done(1, 1, 14, 14);
    check("last_lrst", LRST, 1);
    check("res_img1", RES_IMG, 1);
    check("busy_scoring", BUSY, 1);
    wait_result("lat_img1", 60, 41);
    check("score_two_clusters", RES_SCORE, 40);
    check("rundone_last", RUN_DONE, 1);
    check("busy_drop", BUSY, 0);
    tick();
    check("valid_one_cycle", RES_VALID, 0);
    check("rundone_one_cycle", RUN_DONE, 0);
    give_done(9, 9, 9, 9);
    check("idle_done_ignored", RES_C1X, 1);
    wait_result("idle_done_no_result", 60, 60);

    // Run 2: no coverage on image 0, half coverage on image 1.
    pulse_start();
    repeat (40) tick();
    give_done(15, 15, 15, 15);
    wait_result("lat_r2_img0", 60, 41);
    check("score_far", RES_SCORE, 0);
    give_done(1, 1, 1, 1);
    wait_result("lat_r2_img1", 60, 41);
    check("score_half", RES_SCORE, 20);
    check("rundone_r2", RUN_DONE, 1);

    // Boundary images: point 0 at (0,0), the rest at (15,15).
    for (int i = 0; i < 80; i++) load(i, (i % 40 == 0) ? 8'h00 : 8'hFF);

    // Reset while image 1 streams and image 0 is being scored.
    pulse_start();
    repeat (40) tick();
    give_done(7, 7, 7, 7);
    repeat (10) tick();
    RST = 1'b1;
    #1;
    check("midrst_lrst", LRST, 1);
    check("midrst_busy", BUSY, 0);
    check("midrst_xy", {X, Y}, 0);
    check("midrst_rescx", RES_C1X, 0);
    RST = 1'b0;
    wait_result("midrst_no_result", 60, 60);

    pulse_start();
    check("restart_lrst", LRST, 0);
    check("restart_busy", BUSY, 1);
    check("restart_p0", {X, Y}, 8'h00);
    tick();
    check("restart_p1", {X, Y}, 8'hFF);
    repeat (39) tick();
    give_done(4, 0, 4, 0);
    wait_result("lat_r3_img0", 60, 41);
    check("score_d16_covered", RES_SCORE, 1);
    give_done(4, 1, 4, 1);
    wait_result("lat_r3_img1", 60, 41);
    check("score_d17_not", RES_SCORE, 0);

    // Run 4: loads and START during a run are dropped.
    pulse_start();
    repeat (5) tick();
    LD_EN = 1'b1; LD_ADDR = AW'(40); LD_DATA = 8'hFF; START = 1'b1;
    tick();
    LD_EN = 1'b0; START = 1'b0;
    repeat (34) tick();
    give_done(15, 15, 4, 1);
    wait_result("lat_r4_img0", 60, 41);
    check("score_d450_no_wrap", RES_SCORE, 39);
    give_done(0, 0, 0, 0);
    wait_result("lat_r4_img1", 60, 41);
    check("score_busy_load_dropped", RES_SCORE, 1);
    check("rundone_r4", RUN_DONE, 1);

`ifdef LASER_HOST_TIMEOUT_EN
    tick();
    pulse_start();
    repeat (40) tick();
    repeat (99) tick();
    check("to_err_before", ERR, 0);
    check("to_lrst_before", LRST, 0);
    tick();
    check("to_err", ERR, 1);
    check("to_lrst", LRST, 1);
    check("to_busy", BUSY, 0);
    pulse_start();
    check("to_err_cleared", ERR, 0);
    check("to_restart_busy", BUSY, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
`else
    check("err_tied_low", ERR, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
